// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and sizing helpers for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2,
      ARB_DONE = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } arb_owner_t;

   // Latched command layout, MSB first: {owner, wstrb, addr, wdata}
   function automatic int mem_arb_wd(input int addr_w, input int data_w);
      return 1 + (data_w / 8) + addr_w + data_w;
   endfunction

   function automatic int burst_cnt_w(input int max_burst);
      return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/arb_grant_sel.sv
// Winner selection for the shared memory port plus the saturating data-burst counter
// that keeps a steady stream of data accesses from starving instruction fetch.
module arb_grant_sel
   import mem_port_arbiter_pkg::*;
#(
   parameter int MAX_DATA_BURST = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inst_req,
   input  logic       data_req,
   input  logic       grant_en,
   output arb_owner_t grant_owner
);

   localparam int               CNT_W   = burst_cnt_w(MAX_DATA_BURST);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA_BURST);

   logic [CNT_W-1:0] burst_cnt_q;
   logic             force_inst;

   always_comb begin
      force_inst  = inst_req && (burst_cnt_q == CNT_MAX);
      grant_owner = OWN_DATA;
      if (inst_req && (!data_req || force_inst)) begin
         grant_owner = OWN_INST;
      end
   end

   // Only data grants that actually jump ahead of a waiting fetch count toward the burst
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         burst_cnt_q <= '0;
      end else if (grant_en) begin
         if ((grant_owner == OWN_DATA) && inst_req) begin
            if (burst_cnt_q != CNT_MAX) begin
               burst_cnt_q <= burst_cnt_q + CNT_W'(1);
            end
         end else begin
            burst_cnt_q <= '0;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serializes instruction fetch and data access onto one SRAM-like backing port,
// one outstanding transaction at a time, and stalls the pipeline while either side waits.
//
// state    | meaning
// ARB_IDLE | no transaction; pick a winner and latch its command
// ARB_REQ  | mem_req high with latched command until mem_addr_ok
// ARB_RESP | waiting for mem_data_ok; read data captured on it
// ARB_DONE | one-cycle done pulse to the owner
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int MAX_DATA_BURST = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   output logic [DATA_W-1:0]   inst_rdata,
   output logic                inst_done,
   input  logic                data_req,
   input  logic [DATA_W/8-1:0] data_wen,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                data_done,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stallreq_for_mem
);

   localparam int STRB_W    = DATA_W / 8;
   localparam int CMD_W     = mem_arb_wd(ADDR_W, DATA_W);
   localparam int ADDR_LSB  = DATA_W;
   localparam int STRB_LSB  = DATA_W + ADDR_W;
   localparam int OWNER_BIT = CMD_W - 1;

   arb_state_t          state_q, state_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic [DATA_W-1:0]   inst_rdata_q, data_rdata_q;
   arb_owner_t          grant_owner;
   arb_owner_t          cmd_owner;
   logic [STRB_W-1:0]   cmd_wstrb;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic                cmd_is_write;
   logic                grant_en;
   logic                resp_fire;
   logic                in_req;
   logic                in_done;

   assign cmd_owner    = arb_owner_t'(cmd_q[OWNER_BIT]);
   assign cmd_wstrb    = cmd_q[STRB_LSB +: STRB_W];
   assign cmd_addr     = cmd_q[ADDR_LSB +: ADDR_W];
   assign cmd_wdata    = cmd_q[0 +: DATA_W];
   assign cmd_is_write = (cmd_owner == OWN_DATA) && (cmd_wstrb != '0);

   assign grant_en  = (state_q == ARB_IDLE) && (inst_req || data_req);
   assign resp_fire = (state_q == ARB_RESP) && mem_data_ok;
   assign in_req    = (state_q == ARB_REQ);
   assign in_done   = (state_q == ARB_DONE);

   arb_grant_sel #(
      .MAX_DATA_BURST (MAX_DATA_BURST)
   ) u_grant_sel (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .data_req    (data_req),
      .grant_en    (grant_en),
      .grant_owner (grant_owner)
   );

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      case (state_q)
         ARB_IDLE: begin
            if (grant_en) begin
               state_d = ARB_REQ;
               if (grant_owner == OWN_INST) begin
                  cmd_d = {OWN_INST, {STRB_W{1'b0}}, inst_addr, {DATA_W{1'b0}}};
               end else begin
                  cmd_d = {OWN_DATA, data_wen, data_addr, data_wdata};
               end
            end
         end
         ARB_REQ: begin
            if (mem_addr_ok) begin
               state_d = ARB_RESP;
            end
         end
         ARB_RESP: begin
            if (mem_data_ok) begin
               state_d = ARB_DONE;
            end
         end
         ARB_DONE: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ARB_IDLE;
         cmd_q   <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
      end
   end

   // Write acks carry no data, so data_rdata keeps the last load result
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else if (resp_fire) begin
         if (cmd_owner == OWN_INST) begin
            inst_rdata_q <= mem_rdata;
         end else if (!cmd_is_write) begin
            data_rdata_q <= mem_rdata;
         end
      end
   end

   assign mem_req   = in_req;
   assign mem_wr    = in_req && cmd_is_write;
   assign mem_wstrb = in_req ? cmd_wstrb : '0;
   assign mem_addr  = in_req ? cmd_addr  : '0;
   assign mem_wdata = in_req ? cmd_wdata : '0;

   assign inst_rdata = inst_rdata_q;
   assign data_rdata = data_rdata_q;
   assign inst_done  = in_done && (cmd_owner == OWN_INST);
   assign data_done  = in_done && (cmd_owner == OWN_DATA);

   // Held low while in reset so every output reads zero, even with requests still asserted
   assign stallreq_for_mem = rst && ((inst_req && !inst_done) || (data_req && !data_done));

endmodule
